// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for a CPU load/store
// port. Requests are accepted over valid/ready, wait WAIT_CYCLES, then access an
// internal word array with byte-lane merge on stores and sign/zero extension on
// loads. Misaligned, illegal-size or out-of-range accesses report an error and
// leave memory untouched.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             lat_req;
    logic             mem_we;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      ld_data;
    logic [31:0]      wr_word;
    logic             acc_err;

    assign word_idx = addr_q[IDX_W+1:2];
    assign rd_word  = mem_q[word_idx];

    // Access decode: error check, load extraction and store lane merge
    always_comb begin
        rd_byte = rd_word[7:0];
        rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data = rd_word;
        wr_word = rd_word;
        case (addr_q[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        case (size_q)
            2'b00: begin
                ld_data = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                case (addr_q[1:0])
                    2'd0:    wr_word[7:0]   = wdata_q[7:0];
                    2'd1:    wr_word[15:8]  = wdata_q[7:0];
                    2'd2:    wr_word[23:16] = wdata_q[7:0];
                    default: wr_word[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                ld_data = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
                if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
                else           wr_word[15:0]  = wdata_q[15:0];
            end
            default: begin
                ld_data = rd_word;
                wr_word = wdata_q;
            end
        endcase
        acc_err = (size_q == 2'b11)
                | ((size_q == 2'b01) && addr_q[0])
                | ((size_q == 2'b10) && (addr_q[1:0] != 2'b00))
                | (addr_q[31:2] >= 30'(DEPTH_WORDS));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        lat_req = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    lat_req = 1'b1;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_RESP;
                    err_d   = acc_err;
                    rdata_d = (acc_err || we_q) ? 32'd0 : ld_data;
                    mem_we  = we_q && !acc_err;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // State, request latch and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            if (lat_req) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
            end
        end
    end

    // Word array write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[word_idx] <= wr_word;
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected
// responses, a monitor pops and compares at each response handshake.
module tb_dmem_responder;

    localparam int unsigned W = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        x_valid [2];
    logic        x_ready [2];
    logic        x_we    [2];
    logic [31:0] x_addr  [2];
    logic [1:0]  x_size  [2];
    logic        x_uns   [2];
    logic [31:0] x_wdata [2];
    logic        x_rvalid[2];
    logic        x_rready[2];
    logic [31:0] x_rdata [2];
    logic        x_err   [2];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    // Latency-only instances: WAIT_CYCLES=0 (index 0) and 15 (index 1)
    for (genvar g = 0; g < 2; g++) begin : g_lat
        dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES((g == 0) ? 0 : 15)) u_lat (
            .clk(clk), .reset(reset),
            .req_valid(x_valid[g]), .req_ready(x_ready[g]), .req_we(x_we[g]),
            .req_addr(x_addr[g]), .req_size(x_size[g]), .req_unsigned(x_uns[g]),
            .req_wdata(x_wdata[g]), .rsp_valid(x_rvalid[g]), .rsp_ready(x_rready[g]),
            .rsp_rdata(x_rdata[g]), .rsp_err(x_err[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every response taken by the requester
    always @(negedge clk) begin : mon
        rsp_t e;
        if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response", rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // Issue one request, check accept, latency and response retirement
    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err);
        int b;
        int k;
        @(negedge clk);
        req_we = we; req_addr = addr; req_size = size; req_unsigned = uns;
        req_wdata = wdata; req_valid = 1'b1;
        b = 0;
        while (req_ready !== 1'b1 && b < 20) begin @(negedge clk); b++; end
        chk({name, "_ready"}, 32'(req_ready), 32'd1);
        exp_q.push_back(rsp_t'{rdata: exp_rd, err: exp_err});
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({name, "_busy"}, 32'(req_ready), 32'd0);
        k = 0;
        while (rsp_valid !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
        chk({name, "_lat"}, 32'(k), 32'(W + 1));
        if (rsp_ready) begin
            b = 0;
            while (rsp_valid === 1'b1 && b < 10) begin @(posedge clk); #1; b++; end
            chk({name, "_retire"}, 32'(rsp_valid), 32'd0);
        end
    endtask

    // Word request on a latency instance, check latency and read data
    task automatic x_req(input string name, input int i, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input int exp_lat);
        int b;
        int k;
        @(negedge clk);
        x_we[i] = we; x_addr[i] = addr; x_wdata[i] = wdata; x_valid[i] = 1'b1;
        b = 0;
        while (x_ready[i] !== 1'b1 && b < 20) begin @(negedge clk); b++; end
        @(posedge clk); #1;
        x_valid[i] = 1'b0;
        k = 0;
        while (x_rvalid[i] !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
        chk({name, "_lat"}, 32'(k), 32'(exp_lat));
        chk({name, "_rdata"}, x_rdata[i], exp_rd);
        chk({name, "_err"}, 32'(x_err[i]), 32'd0);
        b = 0;
        while (x_rvalid[i] === 1'b1 && b < 10) begin @(posedge clk); #1; b++; end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            x_valid[i] = 1'b0; x_we[i] = 1'b0; x_addr[i] = '0; x_size[i] = 2'b10;
            x_uns[i] = 1'b0; x_wdata[i] = '0; x_rready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk) reset = 1'b1;

        // Word store/load and sub-word merges
        do_req("st_w10", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req("ld_w10", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        do_req("st_b11", 1'b1, 32'h11, 2'b00, 1'b0, 32'hFFFFFF5A, 32'h0, 1'b0);
        do_req("st_h12", 1'b1, 32'h12, 2'b01, 1'b0, 32'hABCD8001, 32'h0, 1'b0);
        do_req("ld_w10b", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h80015AEF, 1'b0);
        do_req("ld_bs11", 1'b0, 32'h11, 2'b00, 1'b0, 32'h0, 32'h0000005A, 1'b0);
        do_req("ld_hs12", 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 32'hFFFF8001, 1'b0);
        do_req("ld_hu12", 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 32'h00008001, 1'b0);
        do_req("ld_bs10", 1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 32'hFFFFFFEF, 1'b0);
        do_req("ld_bu13", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0);
        do_req("ld_bs13", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req("ld_hu10", 1'b0, 32'h10, 2'b01, 1'b1, 32'h0, 32'h00005AEF, 1'b0);
        do_req("ld_wu10", 1'b0, 32'h10, 2'b10, 1'b1, 32'h0, 32'h80015AEF, 1'b0);

        // Error cases: misaligned, illegal size, out of range; no memory update
        do_req("er_h13", 1'b0, 32'h13, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1);
        do_req("er_w12", 1'b0, 32'h12, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        do_req("er_sz3", 1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
        do_req("er_oor", 1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        do_req("er_oorb", 1'b0, 32'h1003, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        do_req("er_stm", 1'b1, 32'h11, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        do_req("er_sto", 1'b1, 32'h1010, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req("er_sts", 1'b1, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
        do_req("ld_w10c", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h80015AEF, 1'b0);

        // Back-pressure: response held, stray requests ignored
        rsp_ready = 1'b0;
        do_req("hold", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h80015AEF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, 32'h80015AEF);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
            req_size = 2'b10; req_wdata = 32'h0;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_valid", 32'(rsp_valid), 32'd0);
        chk("hold_release_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_no_extra", 32'(rsp_valid), 32'd0);
        end
        do_req("ld_w10d", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h80015AEF, 1'b0);

        // Latency of WAIT_CYCLES=0 and WAIT_CYCLES=15 builds
        x_req("w0_st", 0, 1'b1, 32'h40, 32'hCAFEF00D, 32'h0, 1);
        x_req("w0_ld", 0, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1);
        x_req("w15_st", 1, 1'b1, 32'h44, 32'h0BADF00D, 32'h0, 16);
        x_req("w15_ld", 1, 1'b0, 32'h44, 32'h0, 32'h0BADF00D, 16);

        // Reset during WAIT drops the pending store
        do_req("st_w20", 1'b1, 32'h20, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        do_req("ld_w10e", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h80015AEF, 1'b0);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10; req_unsigned = 1'b0;
        req_wdata = 32'h12345678; req_valid = 1'b1;
        b = 0;
        while (req_ready !== 1'b1 && b < 20) begin @(negedge clk); b++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rstw_req_ready", 32'(req_ready), 32'd1);
        chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstw_rsp_rdata", rsp_rdata, 32'd0);
        chk("rstw_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        do_req("ld_w20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
